store_unit: RTL

Data-memory write port of the RV32I pipeline: the write-side counterpart of the load path feeding `lu_output_in` on the writeback mux. It takes a store from the execute stage and drives one aligned, byte-masked write transaction on the data bus with a valid/ready handshake. Address, data and mask are held stable until the memory accepts, and the block stalls the pipeline while waiting. Misaligned or illegal-size stores are flagged and never reach the bus.

---
 rtl/store_unit.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/store_unit.sv
// rtl/store_unit.sv - RV32I data-memory write port with valid/ready handshake; STORE_TIMEOUT_EN adds a bus timeout
module store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        store_req_in,
    input  logic [1:0]  funct3_in,
    input  logic [31:0] iadder_out_in,
    input  logic [31:0] rs2_in,
    input  logic        dmwr_ready_in,
    output logic        dmwr_valid_out,
    output logic [31:0] dmwr_addr_out,
    output logic [31:0] dmwr_data_out,
    output logic [3:0]  dmwr_mask_out,
    output logic        store_stall_out,
    output logic        misaligned_store_out,
    output logic        bus_error_out
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        legal;
    logic [31:0] enc_data;
    logic [3:0]  enc_mask;
    logic        handshake;
    logic        capture;
    logic        reject;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("store_unit: TIMEOUT_CYCLES must be within 2..255");
    end

`ifdef STORE_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  tmo_cnt;
    logic        timeout;
    logic        bus_err_q;
`endif

    // Size/alignment decode and lane replication of the store data.
    always_comb begin
        legal    = 1'b0;
        enc_data = rs2_in;
        enc_mask = 4'b1111;
        case (funct3_in)
            2'b00: begin
                legal    = 1'b1;
                enc_data = {4{rs2_in[7:0]}};
                enc_mask = 4'b0001 << iadder_out_in[1:0];
            end
            2'b01: begin
                legal    = ~iadder_out_in[0];
                enc_data = {2{rs2_in[15:0]}};
                enc_mask = iadder_out_in[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                legal    = (iadder_out_in[1:0] == 2'b00);
                enc_data = rs2_in;
                enc_mask = 4'b1111;
            end
            default: begin
                legal    = 1'b0;
                enc_data = rs2_in;
                enc_mask = 4'b1111;
            end
        endcase
    end

    assign handshake       = (state == REQ) && dmwr_ready_in;
    assign dmwr_valid_out  = (state == REQ);
    assign store_stall_out = (state == REQ) && !dmwr_ready_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A new store is only taken when the bus is free: in IDLE or on the completing handshake.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        reject     = 1'b0;
`ifdef STORE_TIMEOUT_EN
        timeout    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (store_req_in) begin
                    if (legal) begin
                        capture    = 1'b1;
                        next_state = REQ;
                    end else begin
                        reject     = 1'b1;
                    end
                end
            end
            REQ: begin
                if (handshake) begin
                    next_state = IDLE;
                    if (store_req_in) begin
                        if (legal) begin
                            capture    = 1'b1;
                            next_state = REQ;
                        end else begin
                            reject     = 1'b1;
                        end
                    end
                end
`ifdef STORE_TIMEOUT_EN
                else if (tmo_cnt == TIMEOUT_LIMIT) begin
                    timeout    = 1'b1;
                    next_state = IDLE;
                end
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dmwr_addr_out        <= 32'd0;
            dmwr_data_out        <= 32'd0;
            dmwr_mask_out        <= 4'd0;
            misaligned_store_out <= 1'b0;
        end else begin
            misaligned_store_out <= reject;
            if (capture) begin
                dmwr_addr_out <= {iadder_out_in[31:2], 2'b00};
                dmwr_data_out <= enc_data;
                dmwr_mask_out <= enc_mask;
            end
        end
    end

`ifdef STORE_TIMEOUT_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tmo_cnt   <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= timeout;
            if (capture) begin
                tmo_cnt <= 8'd0;
            end else if (state == REQ && !handshake && !timeout) begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

    assign bus_error_out = bus_err_q;
`else
    assign bus_error_out = 1'b0;
`endif

endmodule
